// File: rtl/arbitro_vc_control_if.sv
// ============================================================================
// Module : arbitro_vc_control_if
// Brief  : VC FIFO heads and D FIFO push path around the VC arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface arbitro_vc_control_if #(
    parameter int DATA_WIDTH = 6
);
    logic [DATA_WIDTH-1:0] vc0_data;
    logic [DATA_WIDTH-1:0] vc1_data;
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic                  vc0_pop;
    logic                  vc1_pop;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  d0_push;
    logic                  d1_push;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        input  vc0_data, vc1_data, vc0_empty, vc1_empty,
        input  d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, data_out
    );

    modport slave (
        output vc0_data, vc1_data, vc0_empty, vc1_empty,
        output d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, data_out
    );
endinterface

`default_nettype wire

// File: rtl/arbitro_vc_control.sv
// ============================================================================
// Module : arbitro_vc_control
// Brief  : Link FSM, threshold latch and weighted VC0/VC1 -> D0/D1 arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arbitro_vc_control #(
    parameter int DATA_WIDTH   = 6,
    parameter int UMBRAL_WIDTH = 4,
    parameter int VC0_WEIGHT   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [UMBRAL_WIDTH-1:0] umbral_MFs_in,
    input  logic [UMBRAL_WIDTH-1:0] umbral_VCs_in,
    input  logic [UMBRAL_WIDTH-1:0] umbral_Ds_in,
    output logic [UMBRAL_WIDTH-1:0] umbral_MFs_out,
    output logic [UMBRAL_WIDTH-1:0] umbral_VCs_out,
    output logic [UMBRAL_WIDTH-1:0] umbral_Ds_out,
    input  logic                    fifo_error,
    input  logic                    all_empty,
    output logic [2:0]              state,
    output logic                    error_out,
    output logic                    active_out,
    output logic                    idle_out,
    arbitro_vc_control_if.master    bus
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int c_DST_BIT  = DATA_WIDTH - 2;
    localparam int c_STREAK_W = (VC0_WEIGHT < 1) ? 1 : $clog2(VC0_WEIGHT + 1);
    localparam logic [c_STREAK_W-1:0] c_WEIGHT = c_STREAK_W'(VC0_WEIGHT);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_error;
    logic                    r_active;
    logic                    r_idle;
    logic [UMBRAL_WIDTH-1:0] r_umbral_mfs;
    logic [UMBRAL_WIDTH-1:0] r_umbral_vcs;
    logic [UMBRAL_WIDTH-1:0] r_umbral_ds;
    logic [c_STREAK_W-1:0]   r_streak;
    logic                    r_d0_push;
    logic                    r_d1_push;
    logic [DATA_WIDTH-1:0]   r_data;

    logic                    w_active;
    logic                    w_vc0_blocked;
    logic                    w_vc1_blocked;
    logic                    w_vc0_elig;
    logic                    w_vc1_elig;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_any_gnt;
    logic [DATA_WIDTH-1:0]   w_word;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET:  w_state_nxt = ST_INIT;
            ST_INIT: begin
                if (fifo_error)      w_state_nxt = ST_ERROR;
                else if (!init)      w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (fifo_error)      w_state_nxt = ST_ERROR;
                else if (init)       w_state_nxt = ST_INIT;
                else if (!all_empty) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (fifo_error)      w_state_nxt = ST_ERROR;
                else if (init)       w_state_nxt = ST_INIT;
                else if (all_empty)  w_state_nxt = ST_IDLE;
            end
            ST_ERROR:  w_state_nxt = ST_ERROR;
            default:   w_state_nxt = ST_RESET;
        endcase
    end

    // Each VC is gated only by the almost-full flag of its own head's destination.
    assign w_active      = (r_state == ST_ACTIVE) && !reset;
    assign w_vc0_blocked = bus.vc0_data[c_DST_BIT] ? bus.d1_almost_full : bus.d0_almost_full;
    assign w_vc1_blocked = bus.vc1_data[c_DST_BIT] ? bus.d1_almost_full : bus.d0_almost_full;
    assign w_vc0_elig    = w_active && !bus.vc0_empty && !w_vc0_blocked;
    assign w_vc1_elig    = w_active && !bus.vc1_empty && !w_vc1_blocked;
    assign w_gnt1        = w_vc1_elig && (!w_vc0_elig || (r_streak == c_WEIGHT));
    assign w_gnt0        = w_vc0_elig && !w_gnt1;
    assign w_any_gnt     = w_gnt0 || w_gnt1;
    assign w_word        = w_gnt1 ? bus.vc1_data : bus.vc0_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RESET;
            r_error      <= 1'b0;
            r_active     <= 1'b0;
            r_idle       <= 1'b0;
            r_umbral_mfs <= '0;
            r_umbral_vcs <= '0;
            r_umbral_ds  <= '0;
            r_streak     <= '0;
            r_d0_push    <= 1'b0;
            r_d1_push    <= 1'b0;
            r_data       <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_error  <= (w_state_nxt == ST_ERROR);
            r_active <= (w_state_nxt == ST_ACTIVE);
            r_idle   <= (w_state_nxt == ST_IDLE);
            if (r_state == ST_INIT) begin
                r_umbral_mfs <= umbral_MFs_in;
                r_umbral_vcs <= umbral_VCs_in;
                r_umbral_ds  <= umbral_Ds_in;
            end
            // The push is registered from the grant, so it lands even if the FSM leaves ACTIVE.
            r_d0_push <= w_any_gnt && !w_word[c_DST_BIT];
            r_d1_push <= w_any_gnt &&  w_word[c_DST_BIT];
            if (w_any_gnt) begin
                r_data <= w_word;
            end
            if (w_gnt1) begin
                r_streak <= '0;
            end else if (w_gnt0 && (r_streak != c_WEIGHT)) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

    assign bus.vc0_pop   = w_gnt0;
    assign bus.vc1_pop   = w_gnt1;
    assign bus.d0_push   = r_d0_push;
    assign bus.d1_push   = r_d1_push;
    assign bus.data_out  = r_data;
    assign state         = r_state;
    assign error_out     = r_error;
    assign active_out    = r_active;
    assign idle_out      = r_idle;
    assign umbral_MFs_out = r_umbral_mfs;
    assign umbral_VCs_out = r_umbral_vcs;
    assign umbral_Ds_out  = r_umbral_ds;

endmodule

`default_nettype wire

// File: tb/tb_arbitro_vc_control.sv
// ============================================================================
// Module : tb_arbitro_vc_control
// Brief  : Directed bench with a reference model and a push scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_arbitro_vc_control;

    localparam int DW = 6;
    localparam int UW = 4;
    localparam int W  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic          fifo_error;
    logic          all_empty;
    logic [UW-1:0] mfs_in, vcs_in, ds_in;
    logic [UW-1:0] mfs_out, vcs_out, ds_out;
    logic [2:0]    state;
    logic          error_out, active_out, idle_out;

    always #5 clk = ~clk;

    arbitro_vc_control_if #(.DATA_WIDTH(DW)) bus ();

    arbitro_vc_control #(
        .DATA_WIDTH  (DW),
        .UMBRAL_WIDTH(UW),
        .VC0_WEIGHT  (W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbral_MFs_in (mfs_in),
        .umbral_VCs_in (vcs_in),
        .umbral_Ds_in  (ds_in),
        .umbral_MFs_out(mfs_out),
        .umbral_VCs_out(vcs_out),
        .umbral_Ds_out (ds_out),
        .fifo_error    (fifo_error),
        .all_empty     (all_empty),
        .state         (state),
        .error_out     (error_out),
        .active_out    (active_out),
        .idle_out      (idle_out),
        .bus           (bus)
    );

    typedef struct packed {
        logic          to_d1;
        logic [DW-1:0] word;
    } exp_t;

    int            checks   = 0;
    int            failures = 0;
    exp_t          sb[$];
    logic [2:0]    m_state  = 3'd0;
    logic [UW-1:0] m_mfs = '0, m_vcs = '0, m_ds = '0;
    int            m_streak = 0;
    logic [DW-1:0] m_data   = '0;
    logic [7:0]    grant_log;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] next_state(input logic [2:0] s);
        if (s == 3'd0) return 3'd1;
        if (s == 3'd4) return 3'd4;
        if (fifo_error) return 3'd4;
        case (s)
            3'd1:    return init ? 3'd1 : 3'd2;
            3'd2:    return init ? 3'd1 : (all_empty ? 3'd2 : 3'd3);
            default: return init ? 3'd1 : (all_empty ? 3'd2 : 3'd3);
        endcase
    endfunction

    // One clock: check pops against the model, queue the expected push, advance, check outputs.
    task automatic cycle(input string tag);
        logic act, blk0, blk1, e0, e1;
        int   g;
        exp_t e;
        logic [2:0] n;
        #1;
        act  = (m_state == 3'd3) && !reset;
        blk0 = bus.vc0_data[DW-2] ? bus.d1_almost_full : bus.d0_almost_full;
        blk1 = bus.vc1_data[DW-2] ? bus.d1_almost_full : bus.d0_almost_full;
        e0   = act && !bus.vc0_empty && !blk0;
        e1   = act && !bus.vc1_empty && !blk1;
        if (e0 && e1)  g = (m_streak >= W) ? 2 : 1;
        else if (e0)   g = 1;
        else if (e1)   g = 2;
        else           g = 0;
        chk({tag, "_vc0_pop"}, 32'(bus.vc0_pop), 32'(g == 1));
        chk({tag, "_vc1_pop"}, 32'(bus.vc1_pop), 32'(g == 2));
        grant_log = {grant_log[6:0], bus.vc1_pop};
        if (g == 1) begin
            e.word = bus.vc0_data;
            e.to_d1 = bus.vc0_data[DW-2];
            sb.push_back(e);
            if (m_streak < W) m_streak++;
        end else if (g == 2) begin
            e.word = bus.vc1_data;
            e.to_d1 = bus.vc1_data[DW-2];
            sb.push_back(e);
            m_streak = 0;
        end
        n = next_state(m_state);
        if (m_state == 3'd1 && !reset) begin
            m_mfs = mfs_in; m_vcs = vcs_in; m_ds = ds_in;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            m_state = 3'd0; m_mfs = '0; m_vcs = '0; m_ds = '0;
            m_streak = 0; m_data = '0; sb.delete();
        end else begin
            m_state = n;
        end
        chk({tag, "_state"},  32'(state),      32'(m_state));
        chk({tag, "_error"},  32'(error_out),  32'(m_state == 3'd4));
        chk({tag, "_active"}, 32'(active_out), 32'(m_state == 3'd3));
        chk({tag, "_idle"},   32'(idle_out),   32'(m_state == 3'd2));
        chk({tag, "_mfs"},    32'(mfs_out),    32'(m_mfs));
        chk({tag, "_vcs"},    32'(vcs_out),    32'(m_vcs));
        chk({tag, "_ds"},     32'(ds_out),     32'(m_ds));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            m_data = e.word;
            chk({tag, "_d0_push"}, 32'(bus.d0_push), 32'(!e.to_d1));
            chk({tag, "_d1_push"}, 32'(bus.d1_push), 32'(e.to_d1));
        end else begin
            chk({tag, "_d0_push"}, 32'(bus.d0_push), 32'd0);
            chk({tag, "_d1_push"}, 32'(bus.d1_push), 32'd0);
        end
        chk({tag, "_data"}, 32'(bus.data_out), 32'(m_data));
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; fifo_error = 1'b0; all_empty = 1'b1;
        mfs_in = 4'd6; vcs_in = 4'd5; ds_in = 4'd3;
        bus.vc0_empty = 1'b1; bus.vc1_empty = 1'b1;
        bus.vc0_data = '0; bus.vc1_data = '0;
        bus.d0_almost_full = 1'b0; bus.d1_almost_full = 1'b0;
        grant_log = '0;

        // Reset, configure, settle in IDLE
        cycle("rst0");
        cycle("rst1");
        chk("rst_state", 32'(state), 32'd0);
        reset = 1'b0; init = 1'b1;
        repeat (3) cycle("init");
        init = 1'b0;
        cycle("to_idle");
        chk("t1_state", 32'(state), 32'd2);
        chk("t1_idle", 32'(idle_out), 32'd1);
        chk("t1_thr", 32'({mfs_out, vcs_out, ds_out}), 32'h653);

        // First word through VC0 -> D0
        all_empty = 1'b0; bus.vc0_empty = 1'b0; bus.vc0_data = 6'b000101;
        cycle("to_active");
        chk("t2_state", 32'(state), 32'd3);
        cycle("t2_pop");
        chk("t2_push", 32'({bus.d0_push, bus.d1_push, bus.data_out}), 32'({2'b10, 6'h05}));
        bus.vc0_empty = 1'b1; bus.vc1_empty = 1'b0; bus.vc1_data = 6'h0A;
        cycle("t2_vc1");

        // Weighted arbitration with both VCs always ready
        bus.vc0_empty = 1'b0; bus.vc0_data = 6'h05;
        grant_log = '0;
        repeat (8) cycle("t3");
        chk("t3_order", 32'(grant_log), 32'h11);

        // Blocked VC0 (to D1) does not stall VC1 (to D0)
        bus.vc0_data = 6'b010001; bus.vc1_data = 6'h03; bus.d1_almost_full = 1'b1;
        repeat (3) cycle("t4_blk");
        bus.d1_almost_full = 1'b0;
        cycle("t4_unblk");
        cycle("t4_push");
        chk("t4_d1_push", 32'({bus.d1_push, bus.data_out}), 32'({1'b1, 6'b010001}));

        // Reset with a transfer in flight
        cycle("t6_pop");
        reset = 1'b1;
        cycle("t6_rst");
        chk("t6_outs", 32'({state, bus.d0_push, bus.d1_push, bus.data_out, mfs_out}), 32'd0);

        // Reconfigure and exercise ACTIVE->INIT and ACTIVE->IDLE
        reset = 1'b0; init = 1'b1; all_empty = 1'b1;
        mfs_in = 4'd9; vcs_in = 4'd2; ds_in = 4'd12;
        bus.vc1_empty = 1'b1; bus.vc0_data = 6'h05;
        cycle("re_init0");
        cycle("re_init1");
        init = 1'b0;
        cycle("re_idle");
        all_empty = 1'b0;
        cycle("re_act");
        cycle("re_pop");
        init = 1'b1;
        cycle("act_to_init");
        init = 1'b0;
        cycle("init_to_idle");
        cycle("idle_to_act");
        all_empty = 1'b1;
        cycle("act_to_idle");
        chk("idle_again", 32'(state), 32'd2);
        all_empty = 1'b0;
        cycle("act_again");

        // Error beats init and is terminal
        fifo_error = 1'b1; init = 1'b1;
        cycle("t5_err");
        chk("t5_state", 32'(state), 32'd4);
        fifo_error = 1'b0;
        repeat (3) cycle("t5_hold");
        chk("t5_error_out", 32'(error_out), 32'd1);
        reset = 1'b1;
        cycle("t5_rst");
        chk("t5_rst_state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
